// File: rtl/apb_exe_pkg.sv
// Shared types and constants for the APB execution-unit initiator:
// sequencer states, transfer indices, register window offsets and status bits.
package apb_exe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef logic [1:0] xfer_idx_t;

   localparam xfer_idx_t IDX_ARGA   = 2'd0;
   localparam xfer_idx_t IDX_ARGB   = 2'd1;
   localparam xfer_idx_t IDX_OPER   = 2'd2;
   localparam xfer_idx_t IDX_RESULT = 2'd3;

   localparam logic [7:0] OFF_ARGA   = 8'h0;
   localparam logic [7:0] OFF_ARGB   = 8'h4;
   localparam logic [7:0] OFF_OPER   = 8'h8;
   localparam logic [7:0] OFF_RESULT = 8'hC;

   // Status nibble sits directly above the result in the RESULT register.
   localparam int STAT_PARITY = 0;
   localparam int STAT_SIGN   = 1;
   localparam int STAT_ZERO   = 2;
   localparam int STAT_ERROR  = 3;
   localparam int STAT_W      = 4;

   function automatic logic [7:0] xfer_offset(input xfer_idx_t idx);
      case (idx)
         IDX_ARGA: xfer_offset = OFF_ARGA;
         IDX_ARGB: xfer_offset = OFF_ARGB;
         IDX_OPER: xfer_offset = OFF_OPER;
         default:  xfer_offset = OFF_RESULT;
      endcase
   endfunction

endpackage

// File: rtl/apb_exe_master_if.sv
// Command, response and APB signal bundle of apb_exe_master.
// Both handshakes transfer exactly on a rising edge where valid && ready;
// the offering side holds its payload stable until that edge.
interface apb_exe_master_if #(
   parameter int WIDTH_ARG  = 8,
   parameter int WIDTH_OPER = 2,
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32
);
   logic                  i_cmd_valid;
   logic                  o_cmd_ready;
   logic [WIDTH_OPER-1:0] i_oper;
   logic [WIDTH_ARG-1:0]  i_argA;
   logic [WIDTH_ARG-1:0]  i_argB;

   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [WIDTH_ARG-1:0]  o_result;
   logic [3:0]            o_status;
   logic                  o_slverr;

   logic                  o_psel;
   logic                  o_penable;
   logic                  o_pwrite;
   logic [ADDR_W-1:0]     o_paddr;
   logic [DATA_W-1:0]     o_pwdata;
   logic [DATA_W-1:0]     i_prdata;
   logic                  i_pready;
   logic                  i_pslverr;

   modport master (
      input  i_cmd_valid, i_oper, i_argA, i_argB, i_rsp_ready,
             i_prdata, i_pready, i_pslverr,
      output o_cmd_ready, o_rsp_valid, o_result, o_status, o_slverr,
             o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );

   modport slave (
      output i_cmd_valid, i_oper, i_argA, i_argB, i_rsp_ready,
             i_prdata, i_pready, i_pslverr,
      input  o_cmd_ready, o_rsp_valid, o_result, o_status, o_slverr,
             o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );

endinterface

// File: rtl/apb_xfer.sv
// Single APB transfer engine: a start pulse loads SETUP, the next edge enters
// ACCESS, and completion drops the bus unless a new start chains straight on.
module apb_xfer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rsn,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_write,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_done,
   output logic              o_err,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready,
   input  logic              i_pslverr
);

   // Completion, error and read data only mean something in the finishing ACCESS cycle.
   assign o_done  = o_psel && o_penable && i_pready;
   assign o_err   = o_done && i_pslverr;
   assign o_rdata = i_prdata;

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         o_psel    <= 1'b0;
         o_penable <= 1'b0;
         o_pwrite  <= 1'b0;
         o_paddr   <= '0;
         o_pwdata  <= '0;
      end else if (i_start) begin
         o_psel    <= 1'b1;
         o_penable <= 1'b0;
         o_pwrite  <= i_write;
         o_paddr   <= i_addr;
         o_pwdata  <= i_write ? i_wdata : '0;
      end else if (o_psel && !o_penable) begin
         o_penable <= 1'b1;
      end else if (o_done) begin
         o_psel    <= 1'b0;
         o_penable <= 1'b0;
         o_pwrite  <= 1'b0;
         o_paddr   <= '0;
         o_pwdata  <= '0;
      end
   end

endmodule

// File: rtl/apb_exe_master.sv
// Offloads one operation to an APB execution unit: writes ARGA, ARGB, OPER,
// reads RESULT, then holds result/status/bus error until the response is taken.
module apb_exe_master
   import apb_exe_pkg::*;
#(
   parameter int WIDTH_ARG  = 8,
   parameter int WIDTH_OPER = 2,
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_rsn,
   apb_exe_master_if.master bus,
   output state_t           o_dbg_state
);

   state_t                state_q;
   xfer_idx_t             idx_q;
   xfer_idx_t             nxt_idx;
   logic [WIDTH_OPER-1:0] oper_q;
   logic [WIDTH_ARG-1:0]  arg_b_q;

   logic                  rsp_valid_q;
   logic [WIDTH_ARG-1:0]  result_q;
   logic [STAT_W-1:0]     status_q;
   logic                  slverr_q;

   logic                  cmd_fire;
   logic                  xfer_start;
   logic [ADDR_W-1:0]     xfer_addr;
   logic                  xfer_write;
   logic [DATA_W-1:0]     xfer_wdata;
   logic                  xfer_done;
   logic                  xfer_err;
   logic [DATA_W-1:0]     xfer_rdata;

   assign bus.o_cmd_ready = (state_q == ST_IDLE);
   assign cmd_fire        = bus.i_cmd_valid && bus.o_cmd_ready;

   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_result    = result_q;
   assign bus.o_status    = status_q;
   assign bus.o_slverr    = slverr_q;
   assign o_dbg_state     = state_q;

   // The next transfer is launched on the same edge that completes the previous
   // one, so ARGA must come straight from the command port at acceptance.
   always_comb begin
      xfer_start = 1'b0;
      nxt_idx    = IDX_ARGA;
      if (state_q == ST_IDLE && cmd_fire) begin
         xfer_start = 1'b1;
         nxt_idx    = IDX_ARGA;
      end else if (state_q == ST_ACCESS && xfer_done && !xfer_err && idx_q != IDX_RESULT) begin
         xfer_start = 1'b1;
         nxt_idx    = idx_q + 2'd1;
      end

      xfer_addr  = ADDR_W'(xfer_offset(nxt_idx));
      xfer_write = (nxt_idx != IDX_RESULT);
      case (nxt_idx)
         IDX_ARGA: xfer_wdata = DATA_W'(bus.i_argA);
         IDX_ARGB: xfer_wdata = DATA_W'(arg_b_q);
         IDX_OPER: xfer_wdata = DATA_W'(oper_q);
         default:  xfer_wdata = '0;
      endcase
   end

   apb_xfer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_xfer (
      .i_clk     (i_clk),
      .i_rsn     (i_rsn),
      .i_start   (xfer_start),
      .i_addr    (xfer_addr),
      .i_write   (xfer_write),
      .i_wdata   (xfer_wdata),
      .o_done    (xfer_done),
      .o_err     (xfer_err),
      .o_rdata   (xfer_rdata),
      .o_psel    (bus.o_psel),
      .o_penable (bus.o_penable),
      .o_pwrite  (bus.o_pwrite),
      .o_paddr   (bus.o_paddr),
      .o_pwdata  (bus.o_pwdata),
      .i_prdata  (bus.i_prdata),
      .i_pready  (bus.i_pready),
      .i_pslverr (bus.i_pslverr)
   );

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state_q     <= ST_IDLE;
         idx_q       <= IDX_ARGA;
         oper_q      <= '0;
         arg_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         result_q    <= '0;
         status_q    <= '0;
         slverr_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_fire) begin
                  oper_q   <= bus.i_oper;
                  arg_b_q  <= bus.i_argB;
                  idx_q    <= IDX_ARGA;
                  slverr_q <= 1'b0;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: state_q <= ST_ACCESS;
            ST_ACCESS: begin
               if (xfer_done) begin
                  if (xfer_err) begin
                     // A bus error abandons the remaining transfers.
                     slverr_q    <= 1'b1;
                     result_q    <= '0;
                     status_q    <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else if (idx_q != IDX_RESULT) begin
                     idx_q   <= nxt_idx;
                     state_q <= ST_SETUP;
                  end else begin
                     result_q    <= xfer_rdata[WIDTH_ARG-1:0];
                     status_q    <= xfer_rdata[WIDTH_ARG+STAT_W-1:WIDTH_ARG];
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (bus.i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic unused_rdata;
   if (DATA_W > WIDTH_ARG + STAT_W) begin : g_rdata_spare
      assign unused_rdata = ^xfer_rdata[DATA_W-1:WIDTH_ARG+STAT_W];
   end else begin : g_rdata_exact
      assign unused_rdata = 1'b0;
   end

endmodule

// File: tb/tb_apb_exe_master.sv
// Directed-plus-random bench for apb_exe_master: acts as the command source,
// the APB execution unit and the response sink, checking against a transfer-list model.
module tb_apb_exe_master;
   import apb_exe_pkg::*;

   localparam int W = 37;

   logic   clk = 1'b0;
   logic   rsn;
   state_t dbg_state;
   int     tests = 0;
   int     fails = 0;
   logic [W-1:0] exp_q[$];

   apb_exe_master_if bus ();

   apb_exe_master dut (
      .i_clk       (clk),
      .i_rsn       (rsn),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is positioned at a negedge; returns at the negedge after the response handshake.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] rd_word, input int err_k, input int wait_k,
                          input int wait_n, input int rsp_delay, input bit hold_valid);
      int n, exp_lat, xfer, waits_left;
      bit got, is_err;
      logic [W-1:0] seen, item;
      logic [7:0] exp_res;
      logic [3:0] exp_st;
      is_err  = (err_k >= 0);
      n       = is_err ? err_k + 1 : 4;
      exp_lat = 2 * n + ((wait_k < n) ? wait_n : 0);
      exp_res = is_err ? 8'h00 : rd_word[7:0];
      exp_st  = is_err ? 4'h0 : rd_word[11:8];
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         logic [31:0] d;
         case (k)
            0:       d = {24'h0, a};
            1:       d = {24'h0, b};
            2:       d = {30'h0, op};
            default: d = 32'h0;
         endcase
         exp_q.push_back({4'(k * 4), 1'(k != 3), d});
      end

      bus.i_cmd_valid = 1'b1;
      bus.i_oper      = op;
      bus.i_argA      = a;
      bus.i_argB      = b;
      check("cmd_ready_idle", 64'(bus.o_cmd_ready), 64'(1));
      @(posedge clk);

      xfer = -1; waits_left = 0; got = 1'b0; seen = '0;
      for (int c = 0; c < 80 && !got; c++) begin
         @(negedge clk);
         if (!hold_valid) bus.i_cmd_valid = 1'b0;
         bus.i_pready  = 1'b0;
         bus.i_pslverr = 1'b0;
         bus.i_prdata  = $urandom;
         if (bus.o_psel && !bus.o_penable) begin
            xfer++;
            waits_left = (xfer == wait_k) ? wait_n : 0;
            seen = {bus.o_paddr, bus.o_pwrite, bus.o_pwdata};
            if (exp_q.size() == 0) check("xfer_count", 64'(xfer), 64'(n - 1));
            else begin
               item = exp_q.pop_front();
               check("setup_xfer", 64'(seen), 64'(item));
            end
            check("busy_cmd_ready", 64'(bus.o_cmd_ready), 64'(0));
         end else if (bus.o_psel && bus.o_penable) begin
            check("access_hold", 64'({bus.o_paddr, bus.o_pwrite, bus.o_pwdata}), 64'(seen));
            if (waits_left > 0) begin
               waits_left--;
               bus.i_pslverr = 1'($urandom);
            end else begin
               bus.i_pready  = 1'b1;
               bus.i_pslverr = (xfer == err_k);
               if (!bus.o_pwrite) bus.i_prdata = rd_word;
            end
         end else if (bus.o_rsp_valid) begin
            got = 1'b1;
            check("rsp_latency", 64'(c), 64'(exp_lat));
            check("rsp_result", 64'(bus.o_result), 64'(exp_res));
            check("rsp_status", 64'(bus.o_status), 64'(exp_st));
            check("rsp_slverr", 64'(bus.o_slverr), 64'(is_err));
            check("xfers_missing", 64'(exp_q.size()), 64'(0));
            check("rsp_state", 64'(dbg_state), 64'(ST_RESP));
         end else begin
            check("bus_active", 64'(bus.o_psel | bus.o_rsp_valid), 64'(1));
         end
      end
      if (!got) check("rsp_timeout", 64'(got), 64'(1));

      for (int d = 0; d < rsp_delay; d++) begin
         bus.i_rsp_ready = 1'b0;
         @(negedge clk);
         check("stall_valid", 64'(bus.o_rsp_valid), 64'(1));
         check("stall_result", 64'({bus.o_result, bus.o_status, bus.o_slverr}),
               64'({exp_res, exp_st, is_err}));
         check("stall_cmd_ready", 64'(bus.o_cmd_ready), 64'(0));
      end
      bus.i_rsp_ready = 1'b1;
      @(negedge clk);
      bus.i_rsp_ready = 1'b0;
      check("post_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
      check("post_rsp_ready", 64'(bus.o_cmd_ready), 64'(1));
      check("post_rsp_psel", 64'(bus.o_psel), 64'(0));
   endtask

   initial begin
      logic [1:0] rop;
      logic [7:0] ra, rb;
      int ek, wk, wn;
      bit found;

      rsn = 1'b0;
      bus.i_cmd_valid = 1'b0; bus.i_oper = '0; bus.i_argA = '0; bus.i_argB = '0;
      bus.i_rsp_ready = 1'b0; bus.i_prdata = '0; bus.i_pready = 1'b0; bus.i_pslverr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_apb", 64'({bus.o_psel, bus.o_penable, bus.o_pwrite, bus.o_paddr, bus.o_pwdata}), 64'(0));
      check("rst_rsp", 64'({bus.o_rsp_valid, bus.o_result, bus.o_status, bus.o_slverr}), 64'(0));
      check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'(1));
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rsn = 1'b1;
      @(negedge clk);

      // ADD example, zero wait states
      run_cmd(2'd0, 8'h05, 8'h03, 32'h0000_0008, -1, -1, 0, 0, 1'b0);
      // three wait states on the ARGB transfer
      run_cmd(2'(($urandom_range(0, 3))), 8'h05, 8'h03, $urandom, -1, 1, 3, 1, 1'b0);
      // bus error on the OPER write
      run_cmd(2'd1, 8'($urandom), 8'($urandom), $urandom, 2, -1, 0, 0, 1'b0);
      // status unpack
      run_cmd(2'd3, 8'h80, 8'($urandom), 32'h0000_0C00, -1, -1, 0, 0, 1'b0);
      // response backpressure with the next command already waiting
      ra = 8'($urandom); rb = 8'($urandom);
      run_cmd(2'd2, ra, rb, $urandom, -1, -1, 0, 5, 1'b1);
      run_cmd(2'd2, ra, rb, $urandom, -1, -1, 0, 0, 1'b0);
      // errors on the first and last transfers
      run_cmd(2'd0, 8'($urandom), 8'($urandom), $urandom, 0, -1, 0, 0, 1'b0);
      run_cmd(2'd1, 8'($urandom), 8'($urandom), $urandom, 3, 3, 2, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         ek  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
         wk  = int'($urandom_range(0, 3));
         wn  = int'($urandom_range(0, 3));
         run_cmd(rop, ra, rb, $urandom, ek, wk, wn, int'($urandom_range(0, 2)), 1'b0);
      end

      // reset while transfer 2 is in ACCESS
      bus.i_cmd_valid = 1'b1;
      bus.i_oper = 2'($urandom); bus.i_argA = 8'($urandom); bus.i_argB = 8'($urandom);
      @(posedge clk);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         bus.i_cmd_valid = 1'b0;
         bus.i_pready    = 1'b0;
         bus.i_pslverr   = 1'b0;
         if (bus.o_psel && bus.o_penable && bus.o_paddr == 4'h8) found = 1'b1;
         else if (bus.o_psel && bus.o_penable) bus.i_pready = 1'b1;
      end
      check("reach_oper_access", 64'(found), 64'(1));
      #2 rsn = 1'b0;
      #1;
      check("mid_rst_apb", 64'({bus.o_psel, bus.o_penable, bus.o_pwrite, bus.o_paddr, bus.o_pwdata}), 64'(0));
      check("mid_rst_rsp", 64'(bus.o_rsp_valid), 64'(0));
      check("mid_rst_ready", 64'(bus.o_cmd_ready), 64'(1));
      @(negedge clk);
      rsn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_quiet", 64'({bus.o_psel, bus.o_rsp_valid}), 64'(0));
      end
      run_cmd(2'd1, 8'h5A, 8'hA5, 32'h0000_0F3C, -1, 2, 1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
